// File: rtl/mips_muldiv_unit_if.sv
// mips_muldiv_unit_if: controller-side bundle for the iterative multiply/divide unit.
//
// Handshake: Start is sampled only while Busy is low; a request seen with
// Busy low is accepted on that edge, together with MDOp, A and B. Busy then
// stays high until the result edge. Done is high for exactly one cycle, the
// cycle in which HI/LO first show the new result, and Busy is already low in
// that cycle, so a new Start may be presented alongside Done. HiWrite/LoWrite
// are honoured only while Busy is low and Start is low.
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MDOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             HiWrite;
    logic             LoWrite;
    logic [WIDTH-1:0] WriteData;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic [1:0]       DbgState;

    modport master (
        output Start, MDOp, A, B, HiWrite, LoWrite, WriteData,
        input  Busy, Done, HI, LO, DbgState
    );

    modport slave (
        input  Start, MDOp, A, B, HiWrite, LoWrite, WriteData,
        output Busy, Done, HI, LO, DbgState
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
// Multiply is radix-2 shift-add on magnitudes, divide is restoring on
// magnitudes; signs are applied in a final FIX cycle.
// Optional feature macro: MULDIV_DIV_EN (defined = divider compiled in;
// undefined = DIV/DIVU complete in one cycle and leave HI/LO untouched).
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic               CLK,
    input logic               RESET,
    mips_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic               busy, accept, mt_en, calc_en, fix_en;

    logic               is_div_q, is_div_d;
    logic               sign_q, sign_d;       // product / quotient sign
    logic               done_q, done_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   opb_q, opb_d;         // multiplier or dividend magnitude, shifted out
    logic [2*WIDTH-1:0] acc_q, acc_d;         // {hi, lo} product or {rem, quo}
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_step, prod;

    assign a_neg    = ~bus.MDOp[0] & bus.A[WIDTH-1];
    assign b_neg    = ~bus.MDOp[0] & bus.B[WIDTH-1];
    assign a_mag    = a_neg ? -bus.A : bus.A;
    assign b_mag    = b_neg ? -bus.B : bus.B;

    // One shift-add step: the carry of the upper-half add shifts back in at the top.
    assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    assign mul_step = opb_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    assign prod     = sign_q ? -acc_q : acc_q;

`ifdef MULDIV_DIV_EN
    logic               rsign_q, rsign_d;     // remainder sign
    logic               dz_q, dz_d;           // divisor was zero
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] div_step;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Partial remainder can reach WIDTH+1 bits after the shift, so the trial
    // compare is one bit wider; the difference itself always fits WIDTH bits.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], opb_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mcand_q};
    assign div_sub   = div_shift[WIDTH-1:0] - mcand_q;
    assign div_step  = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    // With a zero divisor the remainder collects |A|, so re-applying sign(A) returns raw A.
    assign quo_fix   = dz_q ? '1 : (sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem_fix   = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

    // FSM state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
`ifdef MULDIV_DIV_EN
                    state_d = S_CALC;
`else
                    state_d = bus.MDOp[1] ? S_FIX : S_CALC;
`endif
                end
            end
            S_CALC:  if (cnt_q == LAST_ITER) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: per-state datapath enables and Busy
    always_comb begin
        busy    = (state_q != S_IDLE);
        accept  = 1'b0;
        mt_en   = 1'b0;
        calc_en = 1'b0;
        fix_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                accept = bus.Start;
                mt_en  = ~bus.Start;
            end
            S_CALC:  calc_en = 1'b1;
            S_FIX:   fix_en  = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: operand capture, iteration, sign fix-up, MTHI/MTLO
    always_comb begin
        is_div_d = is_div_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = fix_en;
`ifdef MULDIV_DIV_EN
        rsign_d  = rsign_q;
        dz_d     = dz_q;
`endif
        if (accept) begin
            is_div_d = bus.MDOp[1];
            sign_d   = a_neg ^ b_neg;
            mcand_d  = bus.MDOp[1] ? b_mag : a_mag;
            opb_d    = bus.MDOp[1] ? a_mag : b_mag;
            cnt_d    = '0;
            acc_d    = '0;
`ifdef MULDIV_DIV_EN
            rsign_d  = a_neg;
            dz_d     = bus.MDOp[1] && (bus.B == '0);
`endif
        end else if (calc_en) begin
            cnt_d = cnt_q + CW'(1);
`ifdef MULDIV_DIV_EN
            if (is_div_q) begin
                acc_d = div_step;
                opb_d = {opb_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = mul_step;
                opb_d = {1'b0, opb_q[WIDTH-1:1]};
            end
`else
            acc_d = mul_step;
            opb_d = {1'b0, opb_q[WIDTH-1:1]};
`endif
        end else if (fix_en) begin
            if (!is_div_q) begin
                hi_d = prod[2*WIDTH-1:WIDTH];
                lo_d = prod[WIDTH-1:0];
            end
`ifdef MULDIV_DIV_EN
            else begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
`endif
        end else if (mt_en) begin
            if (bus.HiWrite) hi_d = bus.WriteData;
            if (bus.LoWrite) lo_d = bus.WriteData;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

`ifdef MULDIV_DIV_EN
    // Divide-only flags
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
        end
    end
`endif

    assign bus.Busy     = busy;
    assign bus.Done     = done_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.DbgState = state_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: directed and random MULT/MULTU/DIV/DIVU/MTHI/MTLO traffic,
// checked against an arithmetic reference model and an expected-result queue.
module tb_mips_muldiv_unit;
    localparam int W = 32;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_muldiv_unit_if #(.WIDTH(W)) bus ();

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   hi_m, lo_m;
    int             n_vec = 0;
    int             n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: {HI, LO} after an operation, from plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [63:0] cur);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        ref_result = cur;
        case (op)
            2'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                ref_result = sp;
            end
            2'd1: begin
                up = {32'b0, a} * {32'b0, b};
                ref_result = up;
            end
            default: begin
                if (DIV_EN) begin
                    sa = $signed(a);
                    sb = $signed(b);
                    if (b == 0)
                        ref_result = {a, 32'hFFFF_FFFF};
                    else if (op == 2'd3)
                        ref_result = {a % b, a / b};
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                        ref_result = {32'h0, 32'h8000_0000};
                    else
                        ref_result = {32'(sa % sb), 32'(sa / sb)};
                end
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        return (op[1] && !DIV_EN) ? 1 : W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit with_hiwrite);
        logic [63:0] r;
        r = ref_result(op, a, b, {hi_m, lo_m});
        hi_m = r[63:32];
        lo_m = r[31:0];
        exp_q.push_back(r);
        bus.Start     = 1'b1;
        bus.MDOp      = op;
        bus.A         = a;
        bus.B         = b;
        bus.HiWrite   = with_hiwrite;
        bus.WriteData = $urandom;
        @(negedge clk);
        bus.Start   = 1'b0;
        bus.HiWrite = 1'b0;
        bus.A       = $urandom;
        bus.B       = $urandom;
        bus.MDOp    = 2'($urandom_range(0, 3));
        check("busy_after_start", bus.Busy, 1);
    endtask

    task automatic wait_done(input int exp_lat, input int n0);
        int          n;
        logic [63:0] e;
        n = n0;
        while (bus.Done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("sb_depth", 64'(exp_q.size()), 64'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'h0;
        check("hi", bus.HI, e[63:32]);
        check("lo", bus.LO, e[31:0]);
        check("busy_at_done", bus.Busy, 0);
    endtask

    task automatic end_pulse();
        @(negedge clk);
        check("done_pulse", bus.Done, 0);
    endtask

    task automatic mt_write(input bit wh, input bit wl, input logic [W-1:0] d);
        bus.HiWrite   = wh;
        bus.LoWrite   = wl;
        bus.WriteData = d;
        @(negedge clk);
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b0;
        if (wh) hi_m = d;
        if (wl) lo_m = d;
        check("mt_hi", bus.HI, hi_m);
        check("mt_lo", bus.LO, lo_m);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          dones;
        logic [1:0]  op;
        logic [W-1:0] a, b;

        rst           = 1'b1;
        bus.Start     = 1'b0;
        bus.MDOp      = 2'd0;
        bus.A         = '0;
        bus.B         = '0;
        bus.HiWrite   = 1'b0;
        bus.LoWrite   = 1'b0;
        bus.WriteData = '0;
        hi_m          = '0;
        lo_m          = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_hi", bus.HI, 0);
        check("rst_lo", bus.LO, 0);
        check("rst_busy", bus.Busy, 0);
        check("rst_done", bus.Done, 0);

        // Abort a MULT mid-calculation with reset.
        mt_write(1, 1, 32'hA5A5_0001);
        start_op(2'd0, 32'd123, 32'd456, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_hi", bus.HI, 0);
        check("abort_lo", bus.LO, 0);
        check("abort_busy", bus.Busy, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        hi_m  = '0;
        lo_m  = '0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.Done === 1'b1) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        // Directed arithmetic cases.
        start_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        wait_done(lat_of(2'd0), 0);
        end_pulse();
        start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(lat_of(2'd1), 0);
        start_op(2'd1, 32'd2, 32'd3, 1'b0);            // back-to-back in the Done cycle
        wait_done(lat_of(2'd1), 0);
        end_pulse();
        start_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done(lat_of(2'd2), 0);
        end_pulse();
        start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(lat_of(2'd2), 0);
        end_pulse();
        start_op(2'd3, 32'd13, 32'd0, 1'b0);
        wait_done(lat_of(2'd3), 0);
        end_pulse();

        // MTHI in idle, then MTLO and Start during Busy are dropped.
        mt_write(1, 0, 32'h0000_1234);
        start_op(2'd0, 32'd7, 32'hFFFF_FFF7, 1'b0);
        repeat (3) begin
            bus.Start     = 1'b1;
            bus.MDOp      = 2'd3;
            bus.A         = $urandom;
            bus.B         = $urandom;
            bus.LoWrite   = 1'b1;
            bus.WriteData = $urandom;
            @(negedge clk);
            check("busy_ignore", bus.Busy, 1);
        end
        bus.Start   = 1'b0;
        bus.LoWrite = 1'b0;
        wait_done(lat_of(2'd0), 3);
        end_pulse();

        // Random traffic, some back-to-back, some with a dropped HiWrite at acceptance.
        for (int i = 0; i < 48; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            if ($urandom_range(0, 3) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            start_op(op, a, b, 1'($urandom_range(0, 1)));
            wait_done(lat_of(op), 0);
            if ($urandom_range(0, 1) == 1) end_pulse();
        end
        end_pulse();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Iterative multiply/divide unit with HI/LO result registers for the MIPS datapath. It extends the single-cycle ALU with MULT, MULTU, DIV and DIVU, plus MTHI/MTLO writes. Operand width is parametrised. It sits beside MIPSALU: it takes the same A/B operands from the register file and exposes HI/LO to the MFHI/MFLO write-back path. A start/busy/done handshake lets the controller stall while an operation runs.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4 and even.
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- MDOp  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU; sampled with Start.
- A  input  WIDTH  multiplicand / dividend.
- B  input  WIDTH  multiplier / divisor.
- HiWrite  input  1  MTHI: HI <= WriteData.
- LoWrite  input  1  MTLO: LO <= WriteData.
- WriteData  input  WIDTH  data for HiWrite/LoWrite.
- Busy  output  1  high whenever state ≠ IDLE.
- Done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- HI  output  WIDTH  product high half / remainder.
- LO  output  WIDTH  product low half / quotient.

## Operation
- States: IDLE, CALC, FIX.
- IDLE → CALC on Start. At acceptance:
  - latch MDOp;
  - latch |A| and |B| for signed ops, raw values for unsigned ops;
  - latch the result signs: product sign = sign(A)^sign(B); quotient sign = sign(A)^sign(B); remainder sign = sign(A);
  - clear the iteration counter and the 2·WIDTH accumulator.
- CALC runs exactly WIDTH iterations.
  - Multiply: radix-2 shift-add. If the multiplier LSB is 1, add the multiplicand to the accumulator upper half, then shift the whole accumulator right by 1. Keep a carry bit (WIDTH+1-bit add).
  - Divide: restoring. Shift {rem, quo} left by 1, trial-subtract the divisor from rem, keep the result and set quo LSB if it is non-negative.
- CALC → FIX after the WIDTH-th iteration.
- FIX applies sign correction (two's-complement negate where the latched sign is 1), writes HI/LO, pulses Done, then goes to IDLE.
- Divide by zero (B=0, DIV or DIVU): LO = all ones, HI = A (raw, uncorrected). Latency is unchanged.
- Signed overflow (DIV of most-negative by −1): LO = most-negative, HI = 0. This is natural wrap.
- HiWrite/LoWrite take effect only in IDLE and only when Start is low. Otherwise they are dropped.
- Start while Busy is ignored: no queueing, and the operation in flight is unaffected.
- HI/LO hold their value at all other times.

## Timing
- Reset values: state=IDLE, Busy=0, Done=0, HI=0, LO=0. Counter and accumulator are cleared.
- RESET mid-operation aborts immediately. HI/LO go to 0 and no Done is produced.
- Start accepted at edge k:
  - Busy=1 after edge k;
  - iterations at edges k+1 … k+WIDTH;
  - FIX at edge k+WIDTH+1: HI/LO valid, Done=1 and Busy=0 in the following cycle.
  - Latency is WIDTH+1 cycles from acceptance to Done.
- A new Start may be accepted in the same cycle Done is high (back-to-back). Throughput is one operation per WIDTH+2 cycles.
- MTHI/MTLO take one cycle: the value is visible on HI/LO after the sampling edge.
- A and B need only be valid in the acceptance cycle.

## Configuration
- MULDIV_DIV_EN defined: the divider datapath is compiled in and behaves as above.
- MULDIV_DIV_EN undefined: the divider logic is removed.
  - DIV/DIVU are still accepted.
  - IDLE → FIX directly, so Done pulses after edge k+1.
  - HI and LO are left unchanged.
  - Multiply is unaffected.

## Test plan
- Reset then idle: HI=0, LO=0, Busy=0, Done=0. Assert RESET during CALC of a MULT: outputs return to 0 and no Done follows.
- MULT with A=0xFFFFFFFD (−3), B=5: Done 33 cycles after acceptance; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU with A=B=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001. Issue a second MULTU 2×3 in the Done cycle: HI=0, LO=6.
- DIV −7/2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU 13/0: LO=0xFFFFFFFF, HI=0x0000000D. Repeat with MULDIV_DIV_EN undefined: Done after 1 cycle and HI/LO unchanged.
- MTHI 0x1234 in IDLE: HI=0x1234 next cycle. MTLO and a second Start during Busy: both ignored, and the in-flight result is correct.
